// File: rtl/romulus_n_pkg.sv
// Shared definitions for the Romulus-N TK1 controller: FSM states, domain bytes,
// TK1 field offsets and the counter initial value.
package romulus_n_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_AD,
        ST_MSG,
        ST_ISSUE,
        ST_DONE
    } state_t;

    localparam logic [7:0] DOM_AD            = 8'h08;
    localparam logic [7:0] DOM_AD_LAST       = 8'h18;
    localparam logic [7:0] DOM_AD_LAST_PART  = 8'h1A;
    localparam logic [7:0] DOM_MSG           = 8'h04;
    localparam logic [7:0] DOM_MSG_LAST      = 8'h14;
    localparam logic [7:0] DOM_MSG_LAST_PART = 8'h15;

    localparam int unsigned TK1_W       = 128;
    localparam int unsigned TK1_CNT_LSB = 72;
    localparam int unsigned TK1_DOM_LSB = 64;

    localparam logic [55:0] CNT_INIT = 56'h80;

    function automatic logic [7:0] domain_byte(input logic is_msg, input logic last,
                                               input logic partial);
        logic [7:0] d;
        if (!last)
            d = is_msg ? DOM_MSG : DOM_AD;
        else if (partial)
            d = is_msg ? DOM_MSG_LAST_PART : DOM_AD_LAST_PART;
        else
            d = is_msg ? DOM_MSG_LAST : DOM_AD_LAST;
        return d;
    endfunction

endpackage

// File: rtl/romulus_n_tk1_outreg.sv
// Optional registered output stage for TK1: captures a word once, holds it
// until the consumer accepts it.
module romulus_n_tk1_outreg #(
    parameter int unsigned W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // The upstream stays valid until this stage's output is accepted, so the
    // word is loaded only while empty and never reloaded on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end else if (!valid_q && in_valid) begin
            data_q  <= in_data;
            valid_q <= 1'b1;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/romulus_n_tk1_ctrl.sv
// Romulus-N TK1 controller: sequences AD/MSG blocks, builds TK1 and steers the
// external block counter. ROMULUS_TK1_OUTREG_EN adds a registered TK1 output.
module romulus_n_tk1_ctrl
    import romulus_n_pkg::*;
#(
    parameter int unsigned CNT_W = 56,
    parameter int unsigned DOM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             blk_valid,
    input  logic             blk_last,
    input  logic             blk_partial,
    output logic             blk_ready,
    output logic             cnt_sel,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_val,
    output logic [127:0]     tk1,
    output logic             tk1_valid,
    input  logic             tk1_ready,
    output logic             done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DOM_W-1:0]   dom_q;
    logic               last_q;
    logic               phase_msg_q;
    logic [TK1_W-1:0]   tk1_int;
    logic               issue_valid;
    logic               tk1_hs;
    logic               blk_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    assign blk_acc = blk_valid && blk_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            dom_q       <= '0;
            last_q      <= 1'b0;
            phase_msg_q <= 1'b0;
        end else if (blk_acc) begin
            cnt_q       <= cnt_val;
            dom_q       <= DOM_W'(domain_byte(state_q == ST_MSG, blk_last, blk_partial));
            last_q      <= blk_last;
            phase_msg_q <= (state_q == ST_MSG);
        end
    end

    always_comb begin
        tk1_int = '0;
        tk1_int[TK1_CNT_LSB +: CNT_W] = cnt_q;
        tk1_int[TK1_DOM_LSB +: DOM_W] = dom_q;
    end

    assign issue_valid = (state_q == ST_ISSUE);

`ifdef ROMULUS_TK1_OUTREG_EN
    romulus_n_tk1_outreg #(
        .W(TK1_W)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .in_data  (tk1_int),
        .in_valid (issue_valid),
        .out_ready(tk1_ready),
        .out_data (tk1),
        .out_valid(tk1_valid)
    );
`else
    assign tk1       = tk1_int;
    assign tk1_valid = issue_valid;
`endif

    // The FSM leaves ISSUE only on the handshake seen by the SKINNY core.
    assign tk1_hs = tk1_valid && tk1_ready;

    always_comb begin
        state_d   = state_q;
        blk_ready = 1'b0;
        cnt_sel   = 1'b0;
        cnt_en    = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_INIT;
            end
            ST_INIT: begin
                cnt_sel = 1'b1;
                cnt_en  = 1'b1;
                state_d = ST_AD;
            end
            ST_AD, ST_MSG: begin
                blk_ready = 1'b1;
                if (blk_valid)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tk1_hs) begin
                    if (!last_q) begin
                        cnt_en  = 1'b1;
                        state_d = phase_msg_q ? ST_MSG : ST_AD;
                    end else if (!phase_msg_q) begin
                        cnt_en  = 1'b1;
                        cnt_sel = 1'b1;
                        state_d = ST_MSG;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_romulus_n_tk1_ctrl.sv
// Self-checking bench for romulus_n_tk1_ctrl with an external counter model.
module tb_romulus_n_tk1_ctrl;

    localparam int unsigned CNT_W = 56;
    localparam int unsigned DOM_W = 8;
`ifdef ROMULUS_TK1_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             blk_valid;
    logic             blk_last;
    logic             blk_partial;
    logic             blk_ready;
    logic             cnt_sel;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic [127:0]     tk1;
    logic             tk1_valid;
    logic             tk1_ready;
    logic             done;

    int total = 0;
    int bad   = 0;
    int rmode = 0;

    romulus_n_tk1_ctrl #(
        .CNT_W(CNT_W),
        .DOM_W(DOM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .blk_valid  (blk_valid),
        .blk_last   (blk_last),
        .blk_partial(blk_partial),
        .blk_ready  (blk_ready),
        .cnt_sel    (cnt_sel),
        .cnt_en     (cnt_en),
        .cnt_val    (cnt_val),
        .tk1        (tk1),
        .tk1_valid  (tk1_valid),
        .tk1_ready  (tk1_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [55:0] lfsr_step(input logic [55:0] c);
        return {c[54:0], 1'b0} ^ (c[55] ? 56'h95 : 56'h0);
    endfunction

    function automatic logic [55:0] ctr_at(input int unsigned k);
        logic [55:0] c = 56'h80;
        for (int unsigned i = 0; i < k; i++) c = lfsr_step(c);
        return c;
    endfunction

    function automatic logic [7:0] dom_of(input bit msg, input bit last, input bit part);
        if (!last) return msg ? 8'h04 : 8'h08;
        if (part)  return msg ? 8'h15 : 8'h1A;
        return msg ? 8'h14 : 8'h18;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // External counter stage
    always @(posedge clk or posedge rst) begin
        if (rst)
            cnt_val <= '0;
        else if (cnt_en)
            cnt_val <= cnt_sel ? 56'h80 : lfsr_step(cnt_val);
    end

    // Reference model and per-cycle compare
    typedef struct {
        logic [127:0] tk1;
        bit           last_msg;
    } exp_t;

    exp_t         q[$];
    logic [127:0] hs_log[$];
    bit           m_msg;
    int unsigned  m_k;
    bit           exp_done;
    int           sel_cnt;
    bit           lat_wait;
    int           lat_cnt;
    bit           prev_stall;
    logic [127:0] prev_tk1;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_msg = 0; m_k = 0; exp_done = 0; sel_cnt = 0;
            lat_wait = 0; lat_cnt = 0; prev_stall = 0;
        end else begin
            exp_t e;
            chk("done", done, exp_done);
            exp_done = 0;
            chk("sel_without_en", cnt_sel & ~cnt_en, 0);
            if (cnt_sel && cnt_en) sel_cnt++;
            if (tk1_valid) chk("blk_ready_in_issue", blk_ready, 0);
            if (prev_stall) begin
                chk("tk1_stable", tk1, prev_tk1);
                chk("tk1_valid_held", tk1_valid, 1);
            end
            if (tk1_valid && !tk1_ready) chk("cnt_en_stall", cnt_en, 0);
            if (lat_wait) begin
                lat_cnt++;
                if (tk1_valid || lat_cnt > LAT) begin
                    chk("tk1_latency", lat_cnt, LAT);
                    lat_wait = 0;
                end
            end
            if (tk1_valid && tk1_ready) begin
                hs_log.push_back(tk1);
                if (q.size() == 0) begin
                    chk("tk1_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("tk1", tk1, e.tk1);
                    if (e.last_msg) exp_done = 1;
                end
            end
            if (blk_valid && blk_ready) begin
                e.tk1 = {ctr_at(m_k), dom_of(m_msg, blk_last, blk_partial), 64'h0};
                e.last_msg = blk_last && m_msg;
                q.push_back(e);
                if (blk_last) begin
                    m_msg = !m_msg;
                    m_k = 0;
                end else begin
                    m_k++;
                end
                lat_wait = 1;
                lat_cnt = 0;
            end
            if (done) begin
                chk("sel_pulses", sel_cnt, 2);
                sel_cnt = 0;
            end
            prev_stall = tk1_valid && !tk1_ready;
            prev_tk1 = tk1;
        end
    end

    // tk1_ready driver: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        tk1_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       tk1_ready = 1'b1;
                1:       tk1_ready = 1'($urandom % 2);
                default: tk1_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input bit last, input bit part, input bit stray_start);
        int n;
        blk_valid = 1; blk_last = last; blk_partial = part; start = stray_start;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (blk_ready) break;
        end
        if (n == 200) chk("blk_accept_timeout", 1, 0);
        tick();
        blk_valid = 0; start = 0;
        blk_last = 1'($urandom); blk_partial = 1'($urandom);
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 200) chk("done_timeout", 1, 0);
        tick();
        tick();
    endtask

    task automatic wait_tk1_valid();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tk1_valid) break;
        end
        if (n == 50) chk("tk1_valid_timeout", 1, 0);
    endtask

    task automatic run_msg(input int n_ad, input bit ad_part, input int n_msg, input bit msg_part);
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < n_ad; i++)
            send_block(i == n_ad - 1, ad_part && (i == n_ad - 1), i > 0 && ($urandom % 4 == 0));
        for (int i = 0; i < n_msg; i++)
            send_block(i == n_msg - 1, msg_part && (i == n_msg - 1), ($urandom % 4 == 0));
        wait_done();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tk1"}, tk1, 0);
        chk({tag, "_tk1_valid"}, tk1_valid, 0);
        chk({tag, "_blk_ready"}, blk_ready, 0);
        chk({tag, "_cnt_sel"}, cnt_sel, 0);
        chk({tag, "_cnt_en"}, cnt_en, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [127:0] t;
        rst = 1; start = 0; blk_valid = 0; blk_last = 0; blk_partial = 0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        #2 rst = 0;
        tick();

        // Two full AD blocks, one full last MSG block, always ready
        rmode = 0;
        hs_log.delete();
        run_msg(2, 0, 1, 0);
        chk("dir_hs_count", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            t = hs_log[0];
            chk("dir_dom0", t[71:64], 8'h08);
            chk("dir_cnt0", t[127:72], 56'h80);
            chk("dir_low0", t[63:0], 64'h0);
            t = hs_log[1];
            chk("dir_dom1", t[71:64], 8'h18);
            chk("dir_cnt1", t[127:72], 56'h100);
            t = hs_log[2];
            chk("dir_dom2", t[71:64], 8'h14);
            chk("dir_cnt2", t[127:72], 56'h80);
        end

        // Empty AD and empty message: single last+partial blocks
        hs_log.delete();
        run_msg(1, 1, 1, 1);
        chk("part_hs_count", hs_log.size(), 2);
        if (hs_log.size() == 2) begin
            t = hs_log[0];
            chk("part_dom_ad", t[71:64], 8'h1A);
            t = hs_log[1];
            chk("part_dom_msg", t[71:64], 8'h15);
        end

        // Consumer stalls for five cycles in ISSUE
        rmode = 2;
        start = 1;
        tick();
        start = 0;
        send_block(1, 0, 0);
        wait_tk1_valid();
        t = tk1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_tk1", tk1, t);
            chk("stall_blk_ready", blk_ready, 0);
            chk("stall_cnt_en", cnt_en, 0);
        end
        rmode = 0;
        send_block(1, 0, 0);
        wait_done();

        // Reset while a TK1 is pending
        rmode = 2;
        start = 1;
        tick();
        start = 0;
        send_block(0, 0, 0);
        wait_tk1_valid();
        #2 rst = 1;
        #1 chk_outputs_zero("midrst");
        @(negedge clk);
        #2 rst = 0;
        rmode = 0;
        tick();
        run_msg(2, 0, 2, 1);

        // Randomized messages with random consumer backpressure
        rmode = 1;
        for (int it = 0; it < 20; it++)
            run_msg(1 + int'($urandom % 4), 1'($urandom), 1 + int'($urandom % 4), 1'($urandom));
        rmode = 0;
        tick();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
